intr_arbiter: RTL and testbench

//  Multi-source interrupt controller for the MCU. Edge-detects up to N_SRC request lines
//  (debounced buttons, timers) and latches each as pending. Arbitrates among pending,

---
 rtl/intr_pkg.sv | 33 +++
 rtl/intr_edge_det.sv | 20 ++
 rtl/intr_arbiter.sv | 105 ++++++++++
 tb/tb_intr_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// rtl/intr_pkg.sv - shared types, default constants and priority pick for intr_arbiter
package intr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } intr_state_t;

  localparam int N_SRC_DEF     = 4;
  localparam int PULSE_LEN_DEF = 6;
  localparam int ID_W_DEF      = 4;

  // First set bit of req scanning upward from start, wrapping at n.
  function automatic logic [3:0] prio_pick(input logic [15:0] req,
                                           input logic [3:0]  start,
                                           input int unsigned n);
    logic [3:0]  sel;
    logic        found;
    int unsigned idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      idx = (32'(start) + i) % n;
      if (i < n && !found && req[idx[3:0]]) begin
        sel   = idx[3:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/intr_edge_det.sv
// rtl/intr_edge_det.sv - rising-edge detector with per-bit history register
module intr_edge_det #(
  parameter int N = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] evt_o
);

  logic [N-1:0] src_q;

  always_ff @(posedge CLK) begin
    if (RST) src_q <= '0;
    else     src_q <= req_i;
  end

  assign evt_o = req_i & ~src_q;

endmodule

// File: rtl/intr_arbiter.sv
// rtl/intr_arbiter.sv - pending latch, arbiter and pulse FSM; INTR_RR_ARB_EN selects round-robin
module intr_arbiter
  import intr_pkg::*;
#(
  parameter int N_SRC     = N_SRC_DEF,
  parameter int PULSE_LEN = PULSE_LEN_DEF,
  parameter int ID_W      = ID_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_SRC-1:0] src_req,
  input  logic [N_SRC-1:0] src_mask,
  input  logic [N_SRC-1:0] pend_clr,
  output logic             interrupt,
  output logic [ID_W-1:0]  intr_id,
  output logic [N_SRC-1:0] pending,
  output logic             overrun
);

  localparam int CNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  intr_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             interrupt_q;
  logic [ID_W-1:0]  intr_id_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic             overrun_q, overrun_d;
  logic [N_SRC-1:0] evt, req_vec, clr;
  logic [3:0]       start, winner;
  logic             do_grant;
`ifdef INTR_RR_ARB_EN
  logic [3:0]       ptr_q;
`endif

  intr_edge_det #(.N(N_SRC)) u_edge_det (
    .CLK   (CLK),
    .RST   (RST),
    .req_i (src_req),
    .evt_o (evt)
  );

  always_comb begin
    req_vec = pending_q & src_mask;
`ifdef INTR_RR_ARB_EN
    start = (ptr_q == 4'(N_SRC - 1)) ? 4'd0 : ptr_q + 4'd1;
`else
    start = 4'd0;
`endif
    winner    = prio_pick(16'(req_vec), start, N_SRC);
    do_grant  = (state_q == ST_IDLE) && (|req_vec);
    clr       = pend_clr | (do_grant ? (N_SRC'(1) << winner) : '0);
    // A new event beats a same-cycle clear on the same bit.
    pending_d = (pending_q & ~clr) | evt;
    overrun_d = (overrun_q & ~(|pend_clr)) | (|(evt & pending_q & ~clr));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      interrupt_q <= 1'b0;
      intr_id_q   <= '0;
      pending_q   <= '0;
      overrun_q   <= 1'b0;
`ifdef INTR_RR_ARB_EN
      ptr_q       <= 4'(N_SRC - 1);
`endif
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      case (state_q)
        ST_IDLE: begin
          if (do_grant) begin
            intr_id_q   <= ID_W'(winner);
            cnt_q       <= CNT_W'(PULSE_LEN - 1);
            interrupt_q <= 1'b1;
            state_q     <= ST_PULSE;
`ifdef INTR_RR_ARB_EN
            ptr_q       <= winner;
`endif
          end
        end
        ST_PULSE: begin
          if (cnt_q == '0) begin
            interrupt_q <= 1'b0;
            state_q     <= ST_GAP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_GAP: state_q <= ST_IDLE;
        default: begin
          interrupt_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign interrupt = interrupt_q;
  assign intr_id   = intr_id_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_intr_arbiter.sv
// tb/tb_intr_arbiter.sv - scoreboard bench for intr_arbiter (grant id, timing, pending, overrun)
module tb_intr_arbiter;

  localparam int PULSE_LEN = 6;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] src_req  = '0;
  logic [3:0] src_mask = 4'b1111;
  logic [3:0] pend_clr = '0;
  logic       interrupt;
  logic [3:0] intr_id;
  logic [3:0] pending;
  logic       overrun;

  intr_arbiter #(.N_SRC(4), .PULSE_LEN(PULSE_LEN), .ID_W(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .src_req   (src_req),
    .src_mask  (src_mask),
    .pend_clr  (pend_clr),
    .interrupt (interrupt),
    .intr_id   (intr_id),
    .pending   (pending),
    .overrun   (overrun)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int id;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic expect_grant(input int id, input int at);
    exp_t e;
    e.id  = id;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  // Monitor: every rising interrupt is a grant and must match the scoreboard head.
  bit int_prev = 1'b0;
  bit rst_in_pulse = 1'b0;
  int rise_cyc = 0;
  always @(negedge CLK) begin
    exp_t e;
    if (interrupt && !int_prev) begin
      rise_cyc     = cyc;
      rst_in_pulse = 1'b0;
      if (exp_q.size() == 0) begin
        chk("unexpected_grant_id", int'(intr_id), -1);
      end else begin
        e = exp_q.pop_front();
        chk("grant_id", int'(intr_id), e.id);
        chk("grant_cycle", cyc, e.cyc);
      end
    end
    if (RST) rst_in_pulse = 1'b1;
    if (!interrupt && int_prev && !rst_in_pulse)
      chk("pulse_len", cyc - rise_cyc, PULSE_LEN);
    int_prev = interrupt;
  end

  initial begin
    int k;
    int t;

    // Reset state
    tick(3);
    chk("rst_interrupt", int'(interrupt), 0);
    chk("rst_intr_id", int'(intr_id), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_overrun", int'(overrun), 0);
    RST = 1'b0;
    tick(2);

    // Single source 1
    src_req = 4'b0010;
    k = cyc;
    expect_grant(1, k + 2);
    tick(1);
    chk("t1_pending_set", int'(pending), 4'b0010);
    tick(1);
    chk("t1_pending_cleared", int'(pending), 0);
    chk("t1_intr_id", int'(intr_id), 1);
    src_req = 4'b0000;
    tick(10);

    // Simultaneous 0 and 2, fixed priority, 2-cycle gap between pulses
    src_req = 4'b0101;
    k = cyc;
`ifdef INTR_RR_ARB_EN
    expect_grant(2, k + 2);
    expect_grant(0, k + 10);
`else
    expect_grant(0, k + 2);
    expect_grant(2, k + 10);
`endif
    tick(9);
    chk("t2_gap_low", int'(interrupt), 0);
    tick(5);
    src_req = 4'b0000;
    tick(6);
    chk("t2_overrun", int'(overrun), 0);

    // Masked source latches pending, grant on unmask
    src_mask = 4'b1011;
    src_req  = 4'b0100;
    tick(1);
    chk("t4_pending_masked", int'(pending), 4'b0100);
    tick(5);
    chk("t4_no_interrupt", int'(interrupt), 0);
    src_req  = 4'b0000;
    src_mask = 4'b1111;
    k = cyc;
    expect_grant(2, k + 1);
    tick(1);
    chk("t4_intr_id", int'(intr_id), 2);
    chk("t4_pending_cleared", int'(pending), 0);
    tick(10);

    // Overrun on masked pending source, pend_clr, held-high request
    src_mask = 4'b0111;
    src_req  = 4'b1000;
    tick(1);
    chk("t5_pending3", int'(pending), 4'b1000);
    chk("t5_no_overrun", int'(overrun), 0);
    src_req = 4'b0000;
    tick(1);
    src_req = 4'b1000;
    tick(1);
    chk("t5_overrun_set", int'(overrun), 1);
    chk("t5_pending_kept", int'(pending), 4'b1000);
    src_req  = 4'b0000;
    pend_clr = 4'b1000;
    tick(1);
    pend_clr = 4'b0000;
    chk("t5_clr_pending", int'(pending), 0);
    chk("t5_clr_overrun", int'(overrun), 0);
    src_req = 4'b1000;
    tick(50);
    chk("t5_held_pending", int'(pending), 4'b1000);
    chk("t5_held_one_event", int'(overrun), 0);
    pend_clr = 4'b1000;
    tick(1);
    pend_clr = 4'b0000;
    src_req  = 4'b0000;
    src_mask = 4'b1111;
    tick(3);
    chk("t5_final_pending", int'(pending), 0);

    // Reset mid-pulse
    src_req = 4'b0010;
    k = cyc;
    expect_grant(1, k + 2);
    tick(1);
    src_req = 4'b0110;
    tick(3);
    chk("t6_in_pulse", int'(interrupt), 1);
    chk("t6_pending2_before_rst", int'(pending), 4'b0100);
    RST     = 1'b1;
    src_req = 4'b0000;
    tick(1);
    chk("t6_rst_interrupt", int'(interrupt), 0);
    chk("t6_rst_intr_id", int'(intr_id), 0);
    chk("t6_rst_pending", int'(pending), 0);
    RST = 1'b0;
    tick(3);
    src_req = 4'b0010;
    k = cyc;
    expect_grant(1, k + 2);
    tick(10);
    src_req = 4'b0000;
    tick(4);

`ifdef INTR_RR_ARB_EN
    // Round-robin: sources 0 and 1 keep re-firing
    k = cyc;
    expect_grant(0, k + 2);
    expect_grant(1, k + 10);
    expect_grant(0, k + 18);
    expect_grant(1, k + 26);
    for (int i = 0; i < 20; i++) begin
      src_req = (i % 2 == 0) ? 4'b0011 : 4'b0000;
      tick(1);
    end
    src_req = 4'b0000;
    tick(8);
    pend_clr = 4'b0011;
    tick(1);
    pend_clr = 4'b0000;
    tick(12);
`endif

    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      tick(1);
      t++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    tick(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
